// File: rtl/mixer_pkg.sv
// Shared types and defaults for the liquid mixer front end and controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package mixer_pkg;

  // E-stop supervisor states. The encoding is visible on the status output,
  // so these values are part of the interface and must not be reordered.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    TRIPPED = 2'b01,
    ARMED   = 2'b10
  } estop_state_t;

  // Default debounce/synchroniser sizing for a ~200-cycle settle window.
  localparam int WIDTH_DEF           = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 200;
  localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/debounce_cell.sv
// Synchronise one raw asynchronous input and debounce it into a stable level.
// Latency: edge first sampled at edge k shows on o_stable after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
// Backpressure: none; free-running, one sample per clock.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   i_raw    raw asynchronous input
//   o_stable debounced, synchronised level
module debounce_cell #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);

  // Flip on the edge where the counter already holds DEBOUNCE_CYCLES-1 and the
  // inputs still differ: that edge is the DEBOUNCE_CYCLES-th consecutive
  // differing sample. Since the counter clears there it can never wrap.
  localparam logic [WIDTH-1:0] LP_CNT_MAX = WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [WIDTH-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_sync;
  logic                   w_differ;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_sync != r_stable);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (!w_differ) begin
      r_cnt <= '0;
    end else if (r_cnt == LP_CNT_MAX) begin
      r_stable <= w_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/mixer_input_conditioner.sv
// Condition raw operator/sensor inputs into the mixer's x0/x1/x2/x10 inputs.
// Latency: debounce as in debounce_cell; x0 one cycle after debounced start rises; x10/sensor_fault one edge after cause.
// Backpressure: none; purely level/pulse outputs, one update per clock.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   start_raw        raw start pushbutton
//   lvl_low_raw      raw lower level sensor (1 = liquid present)
//   lvl_high_raw     raw upper level sensor (1 = liquid present)
//   estop_raw        raw E-stop (1 = pressed)
//   estop_ack        operator acknowledge level
//   fault_clear      clears latched plausibility fault
//   x0               single-cycle start pulse
//   x1, x2           debounced lower/upper level
//   x10              emergency to mixer
//   sensor_fault     latched plausibility fault
//   estop_state      E-stop FSM state for status display
module mixer_input_conditioner
  import mixer_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_raw,
  input  logic       lvl_low_raw,
  input  logic       lvl_high_raw,
  input  logic       estop_raw,
  input  logic       estop_ack,
  input  logic       fault_clear,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       x10,
  output logic       sensor_fault,
  output logic [1:0] estop_state
);

  logic w_start_db;
  logic w_low_db;
  logic w_high_db;
  logic w_estop_db;

  debounce_cell #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) u_db_start (
    .clk(clk), .rst(rst), .i_raw(start_raw), .o_stable(w_start_db)
  );

  debounce_cell #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) u_db_low (
    .clk(clk), .rst(rst), .i_raw(lvl_low_raw), .o_stable(w_low_db)
  );

  debounce_cell #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) u_db_high (
    .clk(clk), .rst(rst), .i_raw(lvl_high_raw), .o_stable(w_high_db)
  );

  debounce_cell #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) u_db_estop (
    .clk(clk), .rst(rst), .i_raw(estop_raw), .o_stable(w_estop_db)
  );

  // ---------------------------------------------------------------------------
  // E-stop FSM: state register
  // ---------------------------------------------------------------------------
  estop_state_t r_state;
  estop_state_t w_state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // E-stop FSM: next state. A fresh press in ARMED beats a same-cycle ack.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_estop_db) w_state_nxt = TRIPPED;
      end
      TRIPPED: begin
        if (!w_estop_db) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (w_estop_db)     w_state_nxt = TRIPPED;
        else if (estop_ack) w_state_nxt = RUN;
      end
      default: w_state_nxt = TRIPPED;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Plausibility: upper sensor wet while lower is dry cannot be real liquid.
  // A present condition beats fault_clear on the same edge.
  // ---------------------------------------------------------------------------
  logic w_implausible;
  logic w_fault_nxt;
  logic w_x10_nxt;

  // ---------------------------------------------------------------------------
  // E-stop FSM: outputs. x10 is computed from next-state values and then
  // registered, so it changes on the same edge as the state yet is a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_implausible = w_high_db & ~w_low_db;
    w_fault_nxt   = sensor_fault;
    if (w_implausible)   w_fault_nxt = 1'b1;
    else if (fault_clear) w_fault_nxt = 1'b0;
    w_x10_nxt = (w_state_nxt != RUN) | w_fault_nxt;
  end

  logic r_fault;
  logic r_x10;
  logic r_x0;
  logic r_start_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault      <= 1'b0;
      r_x10        <= 1'b1;
      r_x0         <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_fault      <= w_fault_nxt;
      r_x10        <= w_x10_nxt;
      r_start_prev <= w_start_db;
      // Start is swallowed, not deferred, while the emergency output is up.
      r_x0         <= w_start_db & ~r_start_prev & ~r_x10;
    end
  end

  assign x0           = r_x0;
  assign x1           = w_low_db;
  assign x2           = w_high_db;
  assign x10          = r_x10;
  assign sensor_fault = r_fault;
  assign estop_state  = r_state;

endmodule

// File: tb/tb_mixer_input_conditioner.sv
// Directed bench for mixer_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Summary line reports number of checks and number of errors.
`timescale 1ns/1ps
module tb_mixer_input_conditioner;

  logic       clk;
  logic       rst;
  logic       start_raw;
  logic       lvl_low_raw;
  logic       lvl_high_raw;
  logic       estop_raw;
  logic       estop_ack;
  logic       fault_clear;
  logic       x0;
  logic       x1;
  logic       x2;
  logic       x10;
  logic       sensor_fault;
  logic [1:0] estop_state;

  int n_checks = 0;
  int n_errors = 0;
  int x0_hits;

  mixer_input_conditioner #(
    .WIDTH(8), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .start_raw(start_raw), .lvl_low_raw(lvl_low_raw), .lvl_high_raw(lvl_high_raw),
    .estop_raw(estop_raw), .estop_ack(estop_ack), .fault_clear(fault_clear),
    .x0(x0), .x1(x1), .x2(x2), .x10(x10),
    .sensor_fault(sensor_fault), .estop_state(estop_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, counting any cycle where x0 is high.
  task automatic tick_watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (x0) x0_hits++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x0"},    32'(x0), 0);
    check({tag, "_x1"},    32'(x1), 0);
    check({tag, "_x2"},    32'(x2), 0);
    check({tag, "_fault"}, 32'(sensor_fault), 0);
    check({tag, "_state"}, 32'(estop_state), 2);
    check({tag, "_x10"},   32'(x10), 1);
  endtask

  initial begin
    rst = 1'b1; start_raw = 0; lvl_low_raw = 0; lvl_high_raw = 0;
    estop_raw = 0; estop_ack = 0; fault_clear = 0; x0_hits = 0;
    tick(); tick();
    check_reset_vals("rst");
    rst = 1'b0;

    // 1. Acknowledge from ARMED brings x10 down on that edge.
    tick_watch(3);
    check("t1_x10_armed", 32'(x10), 1);
    check("t1_state_armed", 32'(estop_state), 2);
    estop_ack = 1; tick(); estop_ack = 0;
    check("t1_state_run", 32'(estop_state), 0);
    check("t1_x10_run", 32'(x10), 0);

    // 2. Held start: pulse after edge k+6 only, exactly one cycle.
    x0_hits = 0;
    start_raw = 1;
    tick_watch(6);
    check("t2_x0_early", 32'(x0), 0);
    tick();
    check("t2_x0_pulse", 32'(x0), 1);
    tick();
    check("t2_x0_drop", 32'(x0), 0);
    tick_watch(12);
    check("t2_no_second", 32'(x0_hits), 0);
    start_raw = 0;
    tick_watch(8);

    // 3. Short glitch filtered, long pulse passes at k+5.
    lvl_low_raw = 1; tick(); tick(); tick(); lvl_low_raw = 0;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (x1) seen++;
      end
      check("t3_glitch_filtered", 32'(seen), 0);
    end
    lvl_low_raw = 1;
    tick_watch(5);
    check("t3_x1_before", 32'(x1), 0);
    tick();
    check("t3_x1_after", 32'(x1), 1);
    tick_watch(4);
    lvl_low_raw = 0;
    tick_watch(6);
    check("t3_x1_fall", 32'(x1), 0);

    // 4. E-stop trip, ack ignored in TRIPPED, start suppressed, re-arm, ack.
    x0_hits = 0;
    estop_raw = 1;
    tick_watch(7);
    check("t4_state_tripped", 32'(estop_state), 1);
    check("t4_x10_tripped", 32'(x10), 1);
    start_raw = 1; estop_ack = 1;
    tick_watch(1);
    estop_ack = 0;
    check("t4_ack_ignored", 32'(estop_state), 1);
    tick_watch(2);
    estop_raw = 0;
    tick_watch(6);
    check("t4_still_tripped", 32'(estop_state), 1);
    tick_watch(1);
    check("t4_state_armed", 32'(estop_state), 2);
    check("t4_x0_suppressed", 32'(x0_hits), 0);
    start_raw = 0;
    tick_watch(8);
    check("t4_armed_hold", 32'(estop_state), 2);
    estop_ack = 1; tick(); estop_ack = 0;
    check("t4_state_run", 32'(estop_state), 0);
    check("t4_x10_run", 32'(x10), 0);

    // 5. Plausibility fault latch and clear.
    lvl_high_raw = 1;
    tick_watch(6);
    check("t5_x2", 32'(x2), 1);
    check("t5_fault_not_yet", 32'(sensor_fault), 0);
    tick();
    check("t5_fault_set", 32'(sensor_fault), 1);
    check("t5_x10_fault", 32'(x10), 1);
    check("t5_state_run", 32'(estop_state), 0);
    fault_clear = 1; tick(); fault_clear = 0;
    check("t5_clear_blocked", 32'(sensor_fault), 1);
    lvl_low_raw = 1;
    tick_watch(6);
    check("t5_x1", 32'(x1), 1);
    check("t5_fault_held", 32'(sensor_fault), 1);
    fault_clear = 1; tick(); fault_clear = 0;
    check("t5_fault_cleared", 32'(sensor_fault), 0);
    check("t5_x10_clear", 32'(x10), 0);

    // 6. Asynchronous reset mid-debounce while in RUN.
    x0_hits = 0;
    start_raw = 1;
    tick_watch(4);
    rst = 1; #1;
    check_reset_vals("t6_async");
    tick();
    rst = 0;
    tick_watch(12);
    check("t6_no_pulse", 32'(x0_hits), 0);
    check("t6_state", 32'(estop_state), 2);
    check("t6_x10", 32'(x10), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mixer_input_conditioner.md
Name: mixer_input_conditioner

Overview:
Front-end stage that sits directly upstream of the liquid mixer controller and produces its x0/x1/x2/x10 inputs. It synchronises and debounces the raw start button, lower level sensor, upper level sensor and E-stop, and turns the start button into a single-cycle pulse. It latches the E-stop until the operator acknowledges it. It also flags implausible level-sensor combinations, which force the emergency output high.

Parameters:
WIDTH, 8, width of each debounce counter.
DEBOUNCE_CYCLES, 200, consecutive cycles a synchronised input must differ from its stable value before the stable value flips; legal range 2..2**WIDTH.
SYNC_STAGES, 2, flip-flop stages in each input synchroniser; minimum 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start_raw  input  1  raw start pushbutton, active high
lvl_low_raw  input  1  raw lower level sensor, 1 = liquid present
lvl_high_raw  input  1  raw upper level sensor, 1 = liquid present
estop_raw  input  1  raw E-stop, 1 = pressed
estop_ack  input  1  operator acknowledge; level, sampled each cycle
fault_clear  input  1  clears the latched sensor fault; level, sampled each cycle
x0  output  1  start pulse to mixer, one cycle wide
x1  output  1  debounced lower level sensor
x2  output  1  debounced upper level sensor
x10  output  1  emergency to mixer
sensor_fault  output  1  latched plausibility fault
estop_state  output  2  E-stop FSM state, for status display

Behaviour:
- Reset is asynchronous and active-high. Every flip-flop clears immediately when rst rises.
- Reset values: x0=0, x1=0, x2=0, sensor_fault=0, estop_state=ARMED, x10=1.
- Synchroniser: one SYNC_STAGES-deep chain per raw input; all stages reset to 0.
- Debounce cell, one per channel. Each cell holds a stable bit and a WIDTH-bit counter.
  - Synchronised value == stable: the counter clears.
  - Values differ: the counter increments.
  - The counter reaching DEBOUNCE_CYCLES-1 while the values still differ: stable flips and the counter clears in the same edge.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches the output.
  - The counter never wraps.
- Debounce latency: a clean raw edge first sampled at clock edge k appears on the debounced output after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- x1 and x2 are the debounced level channels, driven directly from their stable bits.
- x0 start pulse:
  - A registered rising-edge detect on debounced start drives x0 high for exactly one cycle, on the cycle after debounced start rises.
  - The pulse is suppressed (x0 stays 0) if x10=1 in the cycle the edge is detected.
  - Holding the button produces only one pulse.
- Sensor plausibility:
  - sensor_fault sets on the edge after debounced x2=1 while x1=0.
  - It clears only on an edge where fault_clear=1 and the condition is absent.
  - If fault_clear=1 while the condition is still present, sensor_fault stays 1.
- E-stop FSM, encoding RUN=2'b00, TRIPPED=2'b01, ARMED=2'b10:
  - RUN: debounced estop=1 -> TRIPPED.
  - TRIPPED: debounced estop=0 -> ARMED. estop_ack is ignored in this state.
  - ARMED: debounced estop=1 -> TRIPPED (takes priority over ack). Otherwise estop_ack=1 -> RUN.
  - The illegal code 2'b11 -> TRIPPED.
- x10 = (estop_state != RUN) | sensor_fault. It is driven from registered state only, so it cannot glitch.
- Simultaneous events: a new E-stop press beats ack on the same edge. A new fault beats fault_clear on the same edge.
- Reset mid-operation: all pending debounce counts are discarded. The block returns to ARMED, so the operator must acknowledge before x10 can fall.

Decomposition:
- Shared package mixer_pkg holds:
  - the estop_state_t enum (RUN, TRIPPED, ARMED);
  - the default DEBOUNCE_CYCLES and SYNC_STAGES constants;
  - later, the mixer's state enum.
- One natural sub-module, debounce_cell (parameters WIDTH, DEBOUNCE_CYCLES, SYNC_STAGES), containing synchroniser, counter and stable bit. It is instantiated four times.
- The edge detect, plausibility latch and E-stop FSM stay in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=8.
1. Reset, then hold estop_raw=0 and pulse estop_ack for 1 cycle -> x10 stays 1 until the edge after ack is sampled in ARMED, then 0; estop_state=00.
2. start_raw goes 1 before edge k and is held 20 cycles -> x0=1 for exactly one cycle, after edge k+6; no second pulse while held.
3. lvl_low_raw pulses high for 3 cycles, then a 10-cycle pulse -> x1 ignores the 3-cycle glitch; x1 rises after edge k+5 of the long pulse.
4. With x10=0, estop_raw=1 for 10 cycles, then 0; ack asserted while TRIPPED, then again in ARMED -> estop_state goes 01, then 10, then 00; the first ack has no effect; a start press while TRIPPED gives x0=0.
5. lvl_high_raw=1 with lvl_low_raw=0 -> sensor_fault=1 and x10=1. fault_clear while the condition is present leaves the fault set. Raising lvl_low, then fault_clear=1 -> sensor_fault=0 and x10=0.
6. Assert rst mid-debounce (counter=2) and in RUN -> all outputs immediately take their reset values, estop_state=10, and no x0 pulse after release.
